// File: rtl/cpu_wb_pkg.sv
// Shared types and helpers for the writeback arbiter and its register scoreboard.
package cpu_wb_pkg;

    localparam int NREQ     = 3;
    localparam int REG_AW   = 5;
    localparam int NREG     = 32;
    localparam int XLEN_MAX = 64;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t           rd;
        logic [XLEN_MAX-1:0] data;
    } wb_req_t;

    // Index of the first valid requester, searching upward (with wrap) from start.
    function automatic logic [1:0] pick3(input logic [2:0] valid, input logic [1:0] start);
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] c;
        case (start)
            2'd1:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
            2'd2:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
            default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
        endcase
        if (valid[a]) begin
            pick3 = a;
        end else if (valid[b]) begin
            pick3 = b;
        end else begin
            pick3 = c;
        end
    endfunction

    function automatic logic [5:0] popcount32(input logic [NREG-1:0] v);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + {5'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/cpu_wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register (x0 never busy),
// reservation handshake with WAW stall, and a registered popcount of the busy vector.
module cpu_wb_scoreboard
    import cpu_wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_rd,
    output logic              set_ready,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_rd,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [5:0]        pending_cnt
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;
    logic [5:0]      r_cnt;

    // Clear from the retiring write first, then apply the accepted reservation.
    always_comb begin
        set_ready = !reset && !r_busy[set_rd];
        if (set_en && set_ready) begin
            w_set_mask = 32'd1 << set_rd;
        end else begin
            w_set_mask = 32'd0;
        end
        if (clr_en) begin
            w_clr_mask = 32'd1 << clr_rd;
        end else begin
            w_clr_mask = 32'd0;
        end
        w_busy_nxt = ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
    end

    // Busy vector and its count move on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 32'd0;
            r_cnt  <= 6'd0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= popcount32(w_busy_nxt);
        end
    end

    assign rs1_busy    = r_busy[rs1_addr];
    assign rs2_busy    = r_busy[rs2_addr];
    assign pending_cnt = r_cnt;

endmodule

// File: rtl/cpu_wb_arbiter.sv
// Writeback arbiter: one grant per cycle into a registered regfile write port.
// Define CPU_WB_RR_EN for round-robin arbitration; default is fixed priority 0 > 1 > 2.
module cpu_wb_arbiter
    import cpu_wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREQ = cpu_wb_pkg::NREQ
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0][REG_AW-1:0] req_rd,
    input  logic [NREQ-1:0][XLEN-1:0]   req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic [REG_AW-1:0]           rd_addr,
    output logic [XLEN-1:0]             rd_data,
    output logic                        rd_write_en,
    input  logic                        reserve_en,
    input  logic [REG_AW-1:0]           reserve_rd,
    output logic                        reserve_ready,
    input  logic [REG_AW-1:0]           rs1_addr,
    input  logic [REG_AW-1:0]           rs2_addr,
    output logic                        rs1_busy,
    output logic                        rs2_busy,
    output logic [5:0]                  pending_cnt
);

    logic       w_any;
    logic [1:0] w_idx;
    logic [1:0] w_start;
    wb_req_t    w_sel;
    wb_req_t    r_wb;
    logic       r_wen;
    logic       w_unused_data;

`ifdef CPU_WB_RR_EN
    logic [1:0] r_ptr;

    // Pointer holds the next search origin and moves only when something is granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= 2'd0;
        end else if (w_any) begin
            r_ptr <= (w_idx == 2'd2) ? 2'd0 : w_idx + 2'd1;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign w_start = r_ptr;
`else
    assign w_start = 2'd0;
`endif

    // Combinational grant; nothing is granted while reset is high.
    always_comb begin
        w_any      = |req_valid && !reset;
        w_idx      = pick3(req_valid, w_start);
        w_sel.rd   = req_rd[w_idx];
        w_sel.data = XLEN_MAX'(req_data[w_idx]);
        if (w_any) begin
            req_ready = 3'b001 << w_idx;
        end else begin
            req_ready = 3'b000;
        end
    end

    // Capture the granted writeback; a write to x0 is consumed without enabling the port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb  <= '0;
            r_wen <= 1'b0;
        end else if (w_any) begin
            r_wb  <= w_sel;
            r_wen <= (w_sel.rd != 5'd0);
        end else begin
            r_wb  <= r_wb;
            r_wen <= 1'b0;
        end
    end

    assign rd_addr       = r_wb.rd;
    assign rd_data       = r_wb.data[XLEN-1:0];
    assign rd_write_en   = r_wen;
    assign w_unused_data = ^r_wb.data;

    cpu_wb_scoreboard u_sb (
        .clk         (clk),
        .reset       (reset),
        .set_en      (reserve_en),
        .set_rd      (reserve_rd),
        .set_ready   (reserve_ready),
        .clr_en      (r_wen),
        .clr_rd      (r_wb.rd),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .pending_cnt (pending_cnt)
    );

endmodule

// File: doc/cpu_wb_arbiter.md
CPU_WB_ARBITER -- requirements
Module: cpu_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width (32 or 64).
REQ-002 SHALL have parameter NREQ, default 3, number of writeback requesters; fixed at 3 in this release.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, NREQ, requester k presents a writeback.
REQ-006 SHALL have port req_rd, input, NREQ x 5, destination register per requester.
REQ-007 SHALL have port req_data, input, NREQ x XLEN, writeback data per requester.
REQ-008 SHALL have port req_ready, output, NREQ, one-hot grant; the transfer completes when valid and ready are both high.
REQ-009 SHALL have port rd_addr, output, 5, to the regfile write address.
REQ-010 SHALL have port rd_data, output, XLEN, to the regfile write data.
REQ-011 SHALL have port rd_write_en, output, 1, to the regfile write enable.
REQ-012 SHALL have port reserve_en, input, 1, issue stage requests to mark reserve_rd as pending.
REQ-013 SHALL have port reserve_rd, input, 5, register to reserve.
REQ-014 SHALL have port reserve_ready, output, 1, the reservation is accepted this cycle.
REQ-015 SHALL have ports rs1_addr and rs2_addr, input, 5 each, issue-stage source registers.
REQ-016 SHALL have ports rs1_busy and rs2_busy, output, 1 each, the source register has a pending write.
REQ-017 SHALL have port pending_cnt, output, 6, number of set busy bits (0..31).

Function
REQ-018 SHALL combinationally grant at most one valid requester per cycle and keep req_ready low for non-valid requesters.
REQ-019 SHALL register the granted rd and data into rd_addr/rd_data at the grant edge, and assert rd_write_en for exactly the following cycle; grant-to-write latency is 1 cycle.
REQ-020 SHALL consume a granted request with req_rd=0 but keep rd_write_en low for it.
REQ-021 SHALL sustain one writeback per cycle when requests are back to back.
REQ-022 SHALL hold a busy bit for each of x1..x31; x0 is never busy and rs*_busy for address 0 is always 0.
REQ-023 SHALL set busy[reserve_rd] at the edge where reserve_en and reserve_ready are both high.
REQ-024 SHALL drive reserve_ready = 0 when busy[reserve_rd]=1 (WAW stall), and 1 otherwise, including reserve_rd=0, which sets nothing.
REQ-025 SHALL clear busy[rd_addr] at the edge where rd_write_en=1, the same edge as the regfile write.
REQ-026 SHALL keep rs*_busy high through the cycle in which rd_write_en is high; no bypass is provided.
REQ-027 SHALL NOT allow a reservation to re-set the bit being cleared in the same cycle, because reserve_ready is low while that bit is busy.
REQ-028 SHALL update pending_cnt at the same edge as the busy bits, so it equals the popcount of the registered busy vector.
REQ-029 SHALL ignore a writeback to a non-busy register for scoreboard purposes; the regfile write still occurs.

Reset
REQ-030 SHALL, on reset, immediately clear all busy bits, set pending_cnt=0, rd_write_en=0, rd_addr=0, rd_data=0, and set the round-robin pointer to 0.
REQ-031 SHALL drive req_ready=0 and reserve_ready=0 while reset is high, and discard an in-flight writeback captured before reset.

Configuration
REQ-032 SHALL, with macro CPU_WB_RR_EN defined, arbitrate round-robin: search starts at the requester after the last granted one, and the pointer advances only on a grant.
REQ-033 SHALL, without CPU_WB_RR_EN, arbitrate by fixed priority, requester 0 > 1 > 2, with no pointer state.

Structure
REQ-034 SHALL place NREQ, the register-address width constant and a wb_req_t struct {rd, data} in package cpu_wb_pkg.
REQ-035 SHALL implement the busy vector, reservation logic and popcount in sub-module cpu_wb_scoreboard.

Verification
REQ-036 SHALL cover reserve x5, then req0 writes x5=0xDEADBEEF -> rs1_busy (rs1_addr=5) stays 1 through the write cycle, and the regfile receives 0xDEADBEEF one cycle after the grant; busy clears; pending_cnt goes 1->0.
REQ-037 SHALL cover, without CPU_WB_RR_EN, all three requesters valid for 3 cycles -> grants 0,0,0; with the macro -> grants 0,1,2.
REQ-038 SHALL cover reserve x7 twice with no writeback between -> second reserve_ready=0 and pending_cnt stays 1.
REQ-039 SHALL cover req1 with rd=0, data=0x1234 -> req_ready[1]=1, rd_write_en stays 0, and pending_cnt is unchanged.
REQ-040 SHALL cover reserving x1..x31, then reset asserted mid-stream with a grant in flight -> pending_cnt=0 and rd_write_en=0 immediately, with no write after reset release.
